// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick conditioning, rotate remap and debounced coin pulse.
// Optional P2 keyboard controls are compiled in with ARCADE_INPUT_P2_KEYS_EN.
module arcade_input_mapper #(
  parameter int COIN_PULSE_CYC   = 200000,
  parameter int COIN_HOLDOFF_CYC = 400000,
  parameter int CNT_W            = 20
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [4:0]  p1_ctrl,
  output logic [4:0]  p2_ctrl,
  output logic [1:0]  start,
  output logic        coin,
  output logic        test
);

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_SPACE = 4;
  localparam int K_CTRL  = 5;
  localparam int K_RCTRL = 6;
  localparam int K_F1    = 7;
  localparam int K_1     = 8;
  localparam int K_F2    = 9;
  localparam int K_2     = 10;
  localparam int K_COIN5 = 11;
  localparam int K_COIN6 = 12;
  localparam int K_TEST  = 13;
`ifdef ARCADE_INPUT_P2_KEYS_EN
  localparam int K2_UP    = 14;
  localparam int K2_DOWN  = 15;
  localparam int K2_LEFT  = 16;
  localparam int K2_RIGHT = 17;
  localparam int K2_FIRE  = 18;
  localparam int KEY_N    = 19;
`else
  localparam int KEY_N    = 14;
`endif

  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(COIN_HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_HOLDOFF  = 2'd2,
    ST_WAIT_REL = 2'd3
  } coin_state_t;

  logic             prev_tog_q, prev_tog_d;
  logic             armed_q, armed_d;
  logic [KEY_N-1:0] keys_q, keys_d;
  logic [4:0]       p1_ctrl_q, p1_ctrl_d;
  logic [4:0]       p2_ctrl_q, p2_ctrl_d;
  logic [1:0]       start_q, start_d;
  logic             test_q, test_d;
  logic             coin_q, coin_d;
  logic             coin_req_prev_q, coin_req_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coin_state_t      state_q, state_d;

  logic        evt;
  logic [8:0]  key_code;
  logic [15:0] j;
  logic [4:0]  p1_raw, p2_raw;
  logic        coin_req;
  logic        unused_ok;

  assign unused_ok = ^{joystick_0[15:8], joystick_1[15:8]};

  // Raw vectors are {fire, up, down, left, right}; rotation turns the panel a quarter turn.
  function automatic logic [4:0] remap(input logic [4:0] raw, input logic rot);
    if (rot) remap = {raw[4], raw[1], raw[0], raw[2], raw[3]};
    else     remap = raw;
  endfunction

  always_comb begin
    prev_tog_d = ps2_key[10];
    armed_d    = 1'b1;
    evt        = armed_q && (ps2_key[10] != prev_tog_q);
    key_code   = ps2_key[8:0];
    keys_d     = keys_q;
    if (evt) begin
      case (key_code)
        9'h075, 9'h175: keys_d[K_UP]    = ps2_key[9];
        9'h072, 9'h172: keys_d[K_DOWN]  = ps2_key[9];
        9'h06B, 9'h16B: keys_d[K_LEFT]  = ps2_key[9];
        9'h074, 9'h174: keys_d[K_RIGHT] = ps2_key[9];
        9'h029:         keys_d[K_SPACE] = ps2_key[9];
        9'h014:         keys_d[K_CTRL]  = ps2_key[9];
        9'h114:         keys_d[K_RCTRL] = ps2_key[9];
        9'h005:         keys_d[K_F1]    = ps2_key[9];
        9'h016:         keys_d[K_1]     = ps2_key[9];
        9'h006:         keys_d[K_F2]    = ps2_key[9];
        9'h01E:         keys_d[K_2]     = ps2_key[9];
        9'h02E:         keys_d[K_COIN5] = ps2_key[9];
        9'h036:         keys_d[K_COIN6] = ps2_key[9];
        9'h02C:         keys_d[K_TEST]  = ps2_key[9];
`ifdef ARCADE_INPUT_P2_KEYS_EN
        9'h02D:         keys_d[K2_UP]    = ps2_key[9];
        9'h02B:         keys_d[K2_DOWN]  = ps2_key[9];
        9'h023:         keys_d[K2_LEFT]  = ps2_key[9];
        9'h034:         keys_d[K2_RIGHT] = ps2_key[9];
        9'h01C:         keys_d[K2_FIRE]  = ps2_key[9];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    j      = joystick_0 | joystick_1;
    p1_raw = {keys_q[K_SPACE] | keys_q[K_CTRL] | keys_q[K_RCTRL] | j[4],
              keys_q[K_UP]    | j[3],
              keys_q[K_DOWN]  | j[2],
              keys_q[K_LEFT]  | j[1],
              keys_q[K_RIGHT] | j[0]};
`ifdef ARCADE_INPUT_P2_KEYS_EN
    p2_raw = {keys_q[K2_FIRE]  | j[4],
              keys_q[K2_UP]    | j[3],
              keys_q[K2_DOWN]  | j[2],
              keys_q[K2_LEFT]  | j[1],
              keys_q[K2_RIGHT] | j[0]};
`else
    p2_raw = j[4:0];
`endif
    p1_ctrl_d = remap(p1_raw, rotate);
    p2_ctrl_d = remap(p2_raw, rotate);
    start_d   = {keys_q[K_F2] | keys_q[K_2] | j[6], keys_q[K_F1] | keys_q[K_1] | j[5]};
    test_d    = keys_q[K_TEST];
    coin_req  = keys_q[K_COIN5] | keys_q[K_COIN6] | j[7];
  end

  // Only a fresh rising edge of the merged request starts a pulse; holding never retriggers.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    coin_d          = coin_q;
    coin_req_prev_d = coin_req;
    case (state_q)
      ST_IDLE: begin
        if (coin_req && !coin_req_prev_q) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LOAD;
          coin_d  = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LOAD;
          coin_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = coin_req ? ST_WAIT_REL : ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!coin_req) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        coin_d  = 1'b0;
      end
    endcase
  end

  // coin_req_prev resets high so a request held through reset needs a fresh press.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_tog_q      <= 1'b0;
      armed_q         <= 1'b0;
      keys_q          <= '0;
      p1_ctrl_q       <= '0;
      p2_ctrl_q       <= '0;
      start_q         <= '0;
      test_q          <= 1'b0;
      coin_q          <= 1'b0;
      coin_req_prev_q <= 1'b1;
      cnt_q           <= '0;
      state_q         <= ST_IDLE;
    end else begin
      prev_tog_q      <= prev_tog_d;
      armed_q         <= armed_d;
      keys_q          <= keys_d;
      p1_ctrl_q       <= p1_ctrl_d;
      p2_ctrl_q       <= p2_ctrl_d;
      start_q         <= start_d;
      test_q          <= test_d;
      coin_q          <= coin_d;
      coin_req_prev_q <= coin_req_prev_d;
      cnt_q           <= cnt_d;
      state_q         <= state_d;
    end
  end

  assign p1_ctrl = p1_ctrl_q;
  assign p2_ctrl = p2_ctrl_q;
  assign start   = start_q;
  assign coin    = coin_q;
  assign test    = test_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [4:0]  p1_ctrl;
  logic [4:0]  p2_ctrl;
  logic [1:0]  start;
  logic        coin;
  logic        test;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic tog = 1'b1;

  string      tag_q[$];
  logic [13:0] exp_q[$];

`ifdef ARCADE_INPUT_P2_KEYS_EN
  localparam logic P2K = 1'b1;
`else
  localparam logic P2K = 1'b0;
`endif

  arcade_input_mapper #(
    .COIN_PULSE_CYC(8),
    .COIN_HOLDOFF_CYC(16),
    .CNT_W(20)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .rotate(rotate),
    .p1_ctrl(p1_ctrl),
    .p2_ctrl(p2_ctrl),
    .start(start),
    .coin(coin),
    .test(test)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [13:0] mk(input logic [4:0] p1, input logic [4:0] p2,
                                     input logic [1:0] st, input logic c, input logic t);
    return {p1, p2, st, c, t};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pop_check();
    string       t;
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, {18'd0, p1_ctrl, p2_ctrl, start, coin, test}, {18'd0, e});
    end
  endtask

  task automatic expect_after(input string tag, input int n, input logic [13:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    tick(n);
    pop_check();
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    reset_n    = 1'b0;
    ps2_key    = 11'h675;
    joystick_0 = 16'h0;
    joystick_1 = 16'h0;
    rotate     = 1'b0;
    tick(3);
    check("reset_outputs", {18'd0, p1_ctrl, p2_ctrl, start, coin, test}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) expect_after("no_stale_event", 1, 14'd0);

    send_key(1'b1, 9'h075);
    expect_after("up_latency_edge1", 1, 14'd0);
    expect_after("up_press", 1, mk(5'b01000, 5'b0, 2'b0, 1'b0, 1'b0));
    send_key(1'b0, 9'h075);
    expect_after("up_release", 2, 14'd0);
    send_key(1'b1, 9'h174);
    expect_after("ext_right_press", 2, mk(5'b00001, 5'b0, 2'b0, 1'b0, 1'b0));
    send_key(1'b0, 9'h174);
    expect_after("ext_right_release", 2, 14'd0);

    rotate     = 1'b1;
    joystick_0 = 16'h0002;
    expect_after("rot_left_to_up", 1, mk(5'b01000, 5'b01000, 2'b0, 1'b0, 1'b0));
    joystick_0 = 16'h0008;
    expect_after("rot_up_to_right", 1, mk(5'b00001, 5'b00001, 2'b0, 1'b0, 1'b0));
    joystick_0 = 16'h0;
    rotate     = 1'b0;
    joystick_1 = 16'h0011;
    expect_after("j1_fire_right", 1, mk(5'b10001, 5'b10001, 2'b0, 1'b0, 1'b0));
    joystick_1 = 16'h0;
    expect_after("j1_clear", 1, 14'd0);

    send_key(1'b1, 9'h029);
    expect_after("space_fire", 2, mk(5'b10000, 5'b0, 2'b0, 1'b0, 1'b0));
    send_key(1'b1, 9'h014);
    tick(2);
    send_key(1'b0, 9'h029);
    expect_after("ctrl_holds_fire", 2, mk(5'b10000, 5'b0, 2'b0, 1'b0, 1'b0));
    send_key(1'b1, 9'h114);
    tick(2);
    send_key(1'b0, 9'h014);
    expect_after("rctrl_holds_fire", 2, mk(5'b10000, 5'b0, 2'b0, 1'b0, 1'b0));
    send_key(1'b0, 9'h114);
    expect_after("fire_released", 2, 14'd0);

    send_key(1'b1, 9'h005);
    expect_after("start1_f1", 2, mk(5'b0, 5'b0, 2'b01, 1'b0, 1'b0));
    send_key(1'b1, 9'h01E);
    expect_after("start2_key2", 2, mk(5'b0, 5'b0, 2'b11, 1'b0, 1'b0));
    send_key(1'b0, 9'h005);
    tick(1);
    send_key(1'b0, 9'h01E);
    expect_after("start_released", 2, 14'd0);
    send_key(1'b1, 9'h02C);
    expect_after("test_held", 2, mk(5'b0, 5'b0, 2'b0, 1'b0, 1'b1));
    send_key(1'b0, 9'h02C);
    expect_after("test_released", 2, 14'd0);
    send_key(1'b1, 9'h0AA);
    expect_after("unlisted_ignored", 2, 14'd0);

    joystick_1 = 16'h0080;
    for (int i = 1; i <= 100; i++)
      expect_after("coin_held_once", 1, mk(5'b0, 5'b0, 2'b0, (i <= 8), 1'b0));
    joystick_1 = 16'h0;
    for (int i = 0; i < 17; i++) expect_after("coin_rearm_gap", 1, 14'd0);
    joystick_1 = 16'h0080;
    for (int i = 1; i <= 12; i++)
      expect_after("coin_second_pulse", 1, mk(5'b0, 5'b0, 2'b0, (i <= 8), 1'b0));
    joystick_1 = 16'h0;
    tick(20);

    joystick_0 = 16'h0080;
    send_key(1'b1, 9'h036);
    for (int i = 1; i <= 30; i++)
      expect_after("coin_merge", 1, mk(5'b0, 5'b0, 2'b0, (i <= 8), 1'b0));
    joystick_0 = 16'h0;
    send_key(1'b0, 9'h036);
    tick(4);

    send_key(1'b1, 9'h02E);
    expect_after("coin5_edge1", 1, 14'd0);
    expect_after("coin5_pulse", 1, mk(5'b0, 5'b0, 2'b0, 1'b1, 1'b0));
    for (int i = 3; i <= 45; i++) begin
      if (i == 3)  send_key(1'b0, 9'h02E);
      if (i == 11) send_key(1'b1, 9'h02E);
      if (i == 15) send_key(1'b0, 9'h02E);
      expect_after("coin_holdoff_drop", 1, mk(5'b0, 5'b0, 2'b0, (i <= 9), 1'b0));
    end

    joystick_0 = 16'h0080;
    expect_after("coin_before_reset", 1, mk(5'b0, 5'b0, 2'b0, 1'b1, 1'b0));
    tick(2);
    reset_n = 1'b0;
    #1;
    check("coin_async_reset", {31'd0, coin}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) expect_after("held_after_reset", 1, 14'd0);
    joystick_0 = 16'h0;
    tick(2);
    joystick_0 = 16'h0080;
    expect_after("repress_after_reset", 1, mk(5'b0, 5'b0, 2'b0, 1'b1, 1'b0));
    joystick_0 = 16'h0;
    tick(30);

    send_key(1'b1, 9'h01C);
    expect_after("p2_fire_key", 2, mk(5'b0, {P2K, 4'b0}, 2'b0, 1'b0, 1'b0));
    send_key(1'b0, 9'h01C);
    expect_after("p2_fire_release", 2, 14'd0);
    rotate = 1'b1;
    send_key(1'b1, 9'h02D);
    expect_after("p2_up_rotated", 2, mk(5'b0, {4'b0, P2K}, 2'b0, 1'b0, 1'b0));
    send_key(1'b0, 9'h02D);
    expect_after("p2_up_release", 2, 14'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Input-conditioning stage between hps_io and the galaxian core.
- Decodes PS/2 toggle-event key reports into held-button state and merges it with both joysticks.
- Applies the rotate remap, and produces a fixed-width, debounced coin pulse.
- Its registered outputs drive the core's I_LEFT/I_RIGHT/I_UP/I_DOWN/I_FIRE (P1/P2), start and coin inputs directly.

Parameters:
- COIN_PULSE_CYC, 200000: coin output high time, in clk_sys cycles (must be >= 1).
- COIN_HOLDOFF_CYC, 400000: minimum low time after a pulse before re-arming, in clk_sys cycles (must be >= 1).
- CNT_W, 20: coin counter width; must hold max(COIN_PULSE_CYC, COIN_HOLDOFF_CYC).

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ps2_key, in, 11: [10] toggle on each event, [9] pressed, [8] extended, [7:0] scancode.
- joystick_0, in, 16: bit 0 R, 1 L, 2 D, 3 U, 4 fire, 5 start1, 6 start2, 7 coin.
- joystick_1, in, 16: same bit map as joystick_0.
- rotate, in, 1: 1 = horizontal-orientation remap.
- p1_ctrl, out, 5: {fire, up, down, left, right}.
- p2_ctrl, out, 5: {fire, up, down, left, right}.
- start, out, 2: [0] 1P start, [1] 2P start.
- coin, out, 1: coin pulse.
- test, out, 1: service/test key held.

Interface decision (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: all held-key bits, all outputs, coin FSM state (IDLE), counter and the arm flag clear to 0.
- Event detection:
  - prev_tog register samples ps2_key[10] every cycle.
  - Event = (ps2_key[10] != prev_tog) & armed.
  - The first cycle after reset release only loads prev_tog and sets armed; no decode occurs, so a stale toggle is not treated as an event.
- Decode on event, using key = {ps2_key[8], ps2_key[7:0]}; held bit <= ps2_key[9]:
  - 0x75/0x175 up, 0x72/0x172 down, 0x6B/0x16B left, 0x74/0x174 right.
  - 0x029 space, 0x014 ctrl, 0x114 right-ctrl: three separate held bits. Fire = OR of the three.
  - 0x005 F1 and 0x016 "1" feed start1 as separate bits; 0x006 F2 and 0x01E "2" feed start2 as separate bits.
  - 0x02E "5" and 0x036 "6" are coin keys; 0x02C "T" is test.
  - Unlisted codes: ignored, no state change.
- Joystick merge: j = joystick_0 | joystick_1.
  - P1 raw directions = key | j.
  - P2 raw directions = P2 keys (when compiled in) | j.
- Rotate remap, applied to P1 and P2 independently:
  - rotate=0: pass-through.
  - rotate=1: up<=raw left, down<=raw right, left<=raw down, right<=raw up. Fire is unaffected.
- Latency:
  - All outputs are registered.
  - ps2_key event at edge N -> held bit at edge N -> output at edge N+1.
  - joystick or rotate change -> output after 1 edge.
- Coin FSM. coin_req = any coin key held | j[7].
  - IDLE: a rising edge of coin_req (registered previous value) -> PULSE; counter <= COIN_PULSE_CYC-1; coin <= 1.
  - PULSE: decrement each cycle; on counter==0 -> HOLDOFF; counter <= COIN_HOLDOFF_CYC-1; coin <= 0.
  - HOLDOFF: decrement; on counter==0 -> IDLE if coin_req==0, else WAIT_REL.
  - WAIT_REL: coin_req==0 -> IDLE.
  - A held coin produces exactly one pulse.
  - Simultaneous coin sources merge into one pulse.
  - Requests during PULSE or HOLDOFF are dropped.
  - Coin is high for exactly COIN_PULSE_CYC cycles.
- Reset mid-pulse: coin drops asynchronously and FSM returns to IDLE; after reset, a still-held coin_req does not fire until it is released and pressed again (prev coin_req resets to 1).

Optional Feature:
- Macro: ARCADE_INPUT_P2_KEYS_EN.
- Defined: decode R 0x02D up, F 0x02B down, D 0x023 left, G 0x034 right, A 0x01C fire into P2 held bits, ORed with the joystick.
- Undefined: these codes are ignored, and p2_ctrl derives solely from the joysticks (with remap).

Test Plan (bench parameters COIN_PULSE_CYC=8, COIN_HOLDOFF_CYC=16):
1. Reset with ps2_key[10]=1, release, hold ps2_key static 10 cycles -> all outputs remain 0; no spurious event.
2. Toggle ps2_key to {1'b1-toggle, pressed=1, 0x075}, rotate=0 -> p1_ctrl=5'b01000 two edges later. Repeat with pressed=0 -> 5'b00000.
3. rotate=1, joystick_0=16'h0002 (left) -> p1_ctrl=5'b01000 (up) after 1 edge. joystick_0=16'h0008 (up) -> 5'b00001 (right).
4. Press space and ctrl, release space -> fire stays 1; release ctrl -> fire goes 0.
5. Hold joystick_1[7] for 100 cycles -> coin high exactly 8 cycles, then no second pulse. Release, wait 16 cycles, press again -> second 8-cycle pulse.
6. Press "5" during HOLDOFF, released before it ends -> no pulse. With macro defined, event 0x01C pressed -> p2_ctrl[4]=1; without macro -> p2_ctrl=0.
